// File: rtl/midi_serial_parser_if.sv
// Decoded MIDI event bus driven by midi_serial_parser toward the voice allocator and string model.
// master = parser side (drives), slave = consumer side.
interface midi_serial_parser_if;
    logic [6:0]  note_number;
    logic [6:0]  velocity;
    logic        note_on;
    logic        note_off;
    logic [13:0] pitch;
    logic        pitch_valid;
    logic        frame_error;

    modport master (
        output note_number, velocity, note_on, note_off, pitch, pitch_valid, frame_error
    );

    modport slave (
        input note_number, velocity, note_on, note_off, pitch, pitch_valid, frame_error
    );
endinterface

// File: rtl/midi_serial_parser.sv
// MIDI UART receiver plus running-status channel voice parser (Note On/Off, Pitch Bend).
// Optional macro MIDI_OMNI_EN: when defined, the channel input is ignored (omni mode).
module midi_serial_parser #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 31250
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  midi_rx,
    input  logic [3:0]            channel,
    midi_serial_parser_if.master  bus
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;
    typedef enum logic [1:0] {P_NO_STATUS, P_WAIT_D1, P_WAIT_D2} parse_state_t;

    logic          rx_meta_r, rx_sync_r, rx_prev_r;
    uart_state_t   ustate_r;
    logic [CW-1:0] cnt_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;
    logic          byte_valid_r;
    logic          frame_error_r;

    parse_state_t  pstate_r;
    logic [7:0]    status_r;
    logic [6:0]    d1_r;
    logic [6:0]    note_number_r, velocity_r;
    logic [13:0]   pitch_r;
    logic          note_on_r, note_off_r, pitch_valid_r;
    logic          accept_s;
    logic          one_byte_s;

    // Two-flop synchronizer and edge history for the serial line
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= midi_rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // UART receive FSM; byte_valid and frame_error are single-clock strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            ustate_r      <= U_IDLE;
            cnt_r         <= '0;
            bit_idx_r     <= 3'd0;
            shift_r       <= 8'h00;
            byte_valid_r  <= 1'b0;
            frame_error_r <= 1'b0;
        end else begin
            byte_valid_r  <= 1'b0;
            frame_error_r <= 1'b0;
            case (ustate_r)
                U_IDLE: begin
                    cnt_r <= '0;
                    if (!rx_sync_r && rx_prev_r) begin
                        ustate_r <= U_START;
                    end
                end
                U_START: begin
                    if (cnt_r == CW'(HALF_BIT - 1)) begin
                        cnt_r     <= '0;
                        bit_idx_r <= 3'd0;
                        // A start bit that is high again at mid-bit was only a glitch
                        ustate_r  <= rx_sync_r ? U_IDLE : U_DATA;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                U_DATA: begin
                    if (cnt_r == CW'(CLKS_PER_BIT - 1)) begin
                        cnt_r     <= '0;
                        shift_r   <= {rx_sync_r, shift_r[7:1]};
                        bit_idx_r <= bit_idx_r + 3'd1;
                        if (bit_idx_r == 3'd7) begin
                            ustate_r <= U_STOP;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                U_STOP: begin
                    if (cnt_r == CW'(CLKS_PER_BIT - 1)) begin
                        cnt_r         <= '0;
                        ustate_r      <= U_IDLE;
                        byte_valid_r  <= rx_sync_r;
                        frame_error_r <= !rx_sync_r;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    ustate_r <= U_IDLE;
                    cnt_r    <= '0;
                end
            endcase
        end
    end

`ifdef MIDI_OMNI_EN
    assign accept_s = 1'b1;
`else
    assign accept_s = (status_r[3:0] == channel);
`endif
    assign one_byte_s = (status_r[7:4] == 4'hC) || (status_r[7:4] == 4'hD);

    // Running-status parser with registered message completion
    always_ff @(posedge clk) begin
        if (reset) begin
            pstate_r      <= P_NO_STATUS;
            status_r      <= 8'h00;
            d1_r          <= 7'd0;
            note_number_r <= 7'd0;
            velocity_r    <= 7'd0;
            pitch_r       <= 14'h2000;
            note_on_r     <= 1'b0;
            note_off_r    <= 1'b0;
            pitch_valid_r <= 1'b0;
        end else begin
            note_on_r     <= 1'b0;
            note_off_r    <= 1'b0;
            pitch_valid_r <= 1'b0;
            if (byte_valid_r) begin
                if (shift_r[7:4] == 4'hF) begin
                    // Realtime (F8-FF) leaves everything alone; system common clears running status
                    if (!shift_r[3]) begin
                        pstate_r <= P_NO_STATUS;
                    end
                end else if (shift_r[7]) begin
                    status_r <= shift_r;
                    pstate_r <= P_WAIT_D1;
                end else begin
                    case (pstate_r)
                        P_WAIT_D1: begin
                            d1_r <= shift_r[6:0];
                            if (!one_byte_s) begin
                                pstate_r <= P_WAIT_D2;
                            end
                        end
                        P_WAIT_D2: begin
                            pstate_r <= P_WAIT_D1;
                            if (accept_s) begin
                                case (status_r[7:4])
                                    4'h8, 4'h9: begin
                                        note_number_r <= d1_r;
                                        velocity_r    <= shift_r[6:0];
                                        if ((status_r[7:4] == 4'h9) && (shift_r[6:0] != 7'd0)) begin
                                            note_on_r <= 1'b1;
                                        end else begin
                                            note_off_r <= 1'b1;
                                        end
                                    end
                                    4'hE: begin
                                        pitch_r       <= {shift_r[6:0], d1_r};
                                        pitch_valid_r <= 1'b1;
                                    end
                                    default: begin
                                    end
                                endcase
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    assign bus.note_number = note_number_r;
    assign bus.velocity    = velocity_r;
    assign bus.note_on     = note_on_r;
    assign bus.note_off    = note_off_r;
    assign bus.pitch       = pitch_r;
    assign bus.pitch_valid = pitch_valid_r;
    assign bus.frame_error = frame_error_r;
endmodule

// File: tb/tb_midi_serial_parser.sv
// Directed bench for midi_serial_parser: serial byte driver, pulse monitors, per-scenario tasks.
// CLK_HZ is scaled so a bit lasts 64 clocks, keeping the run short; the glitch is a quarter bit.
module tb_midi_serial_parser;
    localparam int CLK_HZ = 2000000;
    localparam int BAUD   = 31250;
    localparam int N      = CLK_HZ / BAUD;
    localparam int HALF   = N / 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       midi_rx = 1'b1;
    logic [3:0] channel = 4'd0;

    midi_serial_parser_if bus ();

    midi_serial_parser #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk     (clk),
        .reset   (reset),
        .midi_rx (midi_rx),
        .channel (channel),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int on_cnt = 0, off_cnt = 0, pv_cnt = 0, fe_cnt = 0, both_cnt = 0;
    int on_cyc = 0, last_stop_cyc = 0;
    logic [6:0] on_note = 7'd0, on_vel = 7'd0, off_note = 7'd0, off_vel = 7'd0;

    always @(posedge clk) cyc = cyc + 1;

    // Pulse monitors sampled mid-cycle
    always @(negedge clk) begin
        if (bus.note_on) begin
            on_cnt  = on_cnt + 1;
            on_note = bus.note_number;
            on_vel  = bus.velocity;
            on_cyc  = cyc;
        end
        if (bus.note_off) begin
            off_cnt  = off_cnt + 1;
            off_note = bus.note_number;
            off_vel  = bus.velocity;
        end
        if (bus.note_on && bus.note_off) both_cnt = both_cnt + 1;
        if (bus.pitch_valid) pv_cnt = pv_cnt + 1;
        if (bus.frame_error) fe_cnt = fe_cnt + 1;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        midi_rx = 1'b0;
        wait_clks(N);
        for (int i = 0; i < 8; i++) begin
            midi_rx = b[i];
            wait_clks(N);
        end
        midi_rx = stop_bit;
        last_stop_cyc = cyc;
        wait_clks(N);
        midi_rx = 1'b1;
        if (!stop_bit) wait_clks(N);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        wait_clks(3);
        reset = 1'b0;
        wait_clks(2);
        checks++;
        if (bus.note_number !== 7'd0) begin failures++; $display("FAIL reset_note actual=%0d expected=0", bus.note_number); end
        checks++;
        if (bus.velocity !== 7'd0) begin failures++; $display("FAIL reset_vel actual=%0d expected=0", bus.velocity); end
        checks++;
        if (bus.pitch !== 14'h2000) begin failures++; $display("FAIL reset_pitch actual=%h expected=2000", bus.pitch); end
        checks++;
        if ({bus.note_on, bus.note_off, bus.pitch_valid, bus.frame_error} !== 4'b0000) begin
            failures++; $display("FAIL reset_pulses actual=%b expected=0000", {bus.note_on, bus.note_off, bus.pitch_valid, bus.frame_error});
        end
    endtask

    task automatic test_note_on;
        int on0;
        on0 = on_cnt;
        send_byte(8'h90, 1'b1); send_byte(8'h3C, 1'b1); send_byte(8'h64, 1'b1);
        wait_clks(N);
        check_int("note_on_count", on_cnt - on0, 1);
        check_int("note_on_key", on_note, 60);
        check_int("note_on_vel", on_vel, 100);
        checks++;
        if ((on_cyc - last_stop_cyc) < HALF || (on_cyc - last_stop_cyc) >= N) begin
            failures++;
            $display("FAIL note_on_latency actual=%0d expected_range=[%0d,%0d)", on_cyc - last_stop_cyc, HALF, N);
        end
    endtask

    task automatic test_running_status;
        int on0, off0;
        on0 = on_cnt; off0 = off_cnt;
        send_byte(8'h90, 1'b1); send_byte(8'h40, 1'b1); send_byte(8'h50, 1'b1);
        check_int("rs_first_on_count", on_cnt - on0, 1);
        check_int("rs_first_on_key", on_note, 64);
        check_int("rs_first_on_vel", on_vel, 80);
        send_byte(8'h40, 1'b1); send_byte(8'h00, 1'b1);
        wait_clks(4 * N);
        check_int("rs_on_total", on_cnt - on0, 1);
        check_int("rs_off_total", off_cnt - off0, 1);
        check_int("rs_off_key", off_note, 64);
        check_int("rs_off_vel", off_vel, 0);
    endtask

    task automatic test_pitch;
        int pv0;
        pv0 = pv_cnt;
        send_byte(8'hE0, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h40, 1'b1);
        check_int("pitch_center", bus.pitch, 14'h2000);
        check_int("pitch_pv1", pv_cnt - pv0, 1);
        send_byte(8'h7F, 1'b1); send_byte(8'h7F, 1'b1);
        check_int("pitch_max", bus.pitch, 14'h3FFF);
        send_byte(8'h05, 1'b1); send_byte(8'h21, 1'b1);
        check_int("pitch_mixed", bus.pitch, 14'h1085);
        check_int("pitch_pv3", pv_cnt - pv0, 3);
    endtask

    task automatic test_realtime;
        int on0, off0;
        on0 = on_cnt;
        send_byte(8'h90, 1'b1); send_byte(8'h3C, 1'b1); send_byte(8'hF8, 1'b1); send_byte(8'h64, 1'b1);
        check_int("rt_on_count", on_cnt - on0, 1);
        check_int("rt_on_key", on_note, 60);
        check_int("rt_on_vel", on_vel, 100);
        on0 = on_cnt; off0 = off_cnt;
        send_byte(8'hF0, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'hF7, 1'b1);
        send_byte(8'h3C, 1'b1); send_byte(8'h64, 1'b1);
        wait_clks(N);
        check_int("sysex_no_note", (on_cnt - on0) + (off_cnt - off0), 0);
    endtask

    task automatic test_channel;
        int on0;
        channel = 4'd3;
        on0 = on_cnt;
        send_byte(8'h92, 1'b1); send_byte(8'h3C, 1'b1); send_byte(8'h64, 1'b1);
        wait_clks(N);
`ifdef MIDI_OMNI_EN
        check_int("chan_other_count", on_cnt - on0, 1);
`else
        check_int("chan_other_count", on_cnt - on0, 0);
`endif
        on0 = on_cnt;
        send_byte(8'h93, 1'b1); send_byte(8'h3E, 1'b1); send_byte(8'h64, 1'b1);
        check_int("chan_match_count", on_cnt - on0, 1);
        check_int("chan_match_key", on_note, 62);
        channel = 4'd0;
    endtask

    task automatic test_frame;
        int on0, off0, fe0;
        on0 = on_cnt; off0 = off_cnt; fe0 = fe_cnt;
        send_byte(8'h90, 1'b1); send_byte(8'h3C, 1'b1); send_byte(8'h64, 1'b0);
        wait_clks(N);
        check_int("frame_error_count", fe_cnt - fe0, 1);
        check_int("frame_no_note", (on_cnt - on0) + (off_cnt - off0), 0);
    endtask

    task automatic test_glitch;
        int on0, fe0;
        on0 = on_cnt; fe0 = fe_cnt;
        send_byte(8'h90, 1'b1); send_byte(8'h3C, 1'b1);
        midi_rx = 1'b0;
        wait_clks(N / 4);
        midi_rx = 1'b1;
        wait_clks(HALF);
        send_byte(8'h64, 1'b1);
        wait_clks(N);
        check_int("glitch_on_count", on_cnt - on0, 1);
        check_int("glitch_on_vel", on_vel, 100);
        check_int("glitch_no_fe", fe_cnt - fe0, 0);
    endtask

    task automatic test_reset_mid;
        int on0;
        send_byte(8'h90, 1'b1); send_byte(8'h3C, 1'b1);
        midi_rx = 1'b0;
        wait_clks(N);
        for (int i = 0; i < 3; i++) begin
            midi_rx = 1'b0;
            wait_clks(N);
        end
        reset = 1'b1;
        midi_rx = 1'b1;
        wait_clks(2);
        reset = 1'b0;
        wait_clks(1);
        check_int("rmid_note", bus.note_number, 0);
        check_int("rmid_vel", bus.velocity, 0);
        check_int("rmid_pitch", bus.pitch, 14'h2000);
        on0 = on_cnt;
        wait_clks(2 * N);
        check_int("rmid_no_pulse", on_cnt - on0, 0);
        send_byte(8'h90, 1'b1); send_byte(8'h45, 1'b1); send_byte(8'h30, 1'b1);
        check_int("rmid_after_count", on_cnt - on0, 1);
        check_int("rmid_after_key", on_note, 69);
        check_int("rmid_after_vel", on_vel, 48);
    endtask

    initial begin
        test_reset();
        test_note_on();
        test_running_status();
        test_pitch();
        test_realtime();
        test_channel();
        test_frame();
        test_glitch();
        test_reset_mid();
        check_int("on_off_exclusive", both_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/midi_serial_parser.md
Name: midi_serial_parser

Overview:
- Front end of the synth voice path: receives the raw 31250-baud MIDI serial line and decodes channel voice messages.
- Produces the note_number / velocity / note_on / note_off / pitch signals that the voice allocator and string-model blocks consume.
- Contains a UART receiver plus a running-status message parser.
- Runs entirely in the system clock domain.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 31250, serial bit rate.
- CLKS_PER_BIT, CLK_HZ/BAUD (1600), clocks per bit period; derived, not overridden.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- midi_rx  input  1  asynchronous MIDI serial line; idle high.
- channel  input  4  MIDI channel to accept (0–15); quasi-static.
- note_number  output  7  key of the last accepted Note On/Off.
- velocity  output  7  velocity of the last accepted Note On/Off.
- note_on  output  1  one-clk pulse for an accepted Note On with velocity ≠ 0.
- note_off  output  1  one-clk pulse for an accepted Note Off, or Note On with velocity 0.
- pitch  output  14  last accepted pitch bend value, {MSB[6:0], LSB[6:0]}.
- pitch_valid  output  1  one-clk pulse when pitch updates.
- frame_error  output  1  one-clk pulse when a received byte has a bad stop bit.

Behaviour:
- Reset values:
  - note_number = 0, velocity = 0, pitch = 14'h2000 (center).
  - All pulse outputs = 0.
  - Running status cleared; UART in IDLE; synchronizer flops preset to 1.
- Input sync: midi_rx passes through a 2-FF synchronizer. All decisions use the synced value.
- UART FSM:
  - IDLE: falling edge on synced rx → START, with bit counter reset.
  - START: at CLKS_PER_BIT/2 (800), re-sample. If low → DATA; if high, treat as a glitch → IDLE.
  - DATA: sample every CLKS_PER_BIT at bit centers; 8 bits, LSB first.
  - STOP: sample after one more bit period.
    - Sample 1 → byte_valid internal strobe for one clk.
    - Sample 0 → frame_error pulse, byte discarded, parser state untouched.
    - In both cases, return to IDLE. A new start bit may be detected from the next clk.
- Parser, on each byte_valid:
  - 0xF8–0xFF (realtime): ignored entirely. Running status and data-byte position are unchanged, even mid-message.
  - 0xF0–0xF7: clear running status. Following data bytes are discarded until the next status byte.
  - 0x80–0xEF: latch as running status and go to WAIT_D1.
    - Message is "accepted" if status[3:0] == channel.
    - Message types 0x8, 0x9, 0xE are handled. Other types (0xA–0xD) are tracked for byte counting but produce no output.
    - Types 0xC and 0xD have one data byte; all others have two.
  - Data byte (bit 7 = 0), by state:
    - NO_STATUS: discard.
    - WAIT_D1: store as d1. For a 1-byte type, complete the message and stay in WAIT_D1; otherwise go to WAIT_D2.
    - WAIT_D2: complete the message; return to WAIT_D1 (running status).
- Completion (registered; outputs change on the clk after the byte_valid of the final byte):
  - 0x9n, vel ≠ 0: note_number = d1, velocity = d2, note_on = 1.
  - 0x9n with vel = 0, or 0x8n: note_number = d1, velocity = d2, note_off = 1.
  - 0xEn: pitch = {d2, d1}, pitch_valid = 1.
  - Not accepted (channel mismatch): no output change, no pulse.
- A status byte arriving in WAIT_D2 abandons the partial message without producing output.
- note_on and note_off are never asserted in the same clk.
- Reset asserted mid-byte or mid-message: everything returns to reset values on the next clk. A partially received byte is lost.

Optional Feature:
- Macro: MIDI_OMNI_EN.
- Defined: the channel input is ignored and every channel voice message is accepted (omni mode).
- Undefined: only messages whose status low nibble equals channel are accepted.

Test Plan:
- Reset, then send 0x90 0x3C 0x64 with channel = 0 at 1600 clk/bit → one note_on pulse, note_number = 60, velocity = 100, one clk after the last stop-bit sample.
- Running status: 0x90 0x40 0x50 0x40 0x00 → note_on (64, 80), then note_off (64, 0); no third pulse.
- Pitch bend: 0xE0 0x00 0x40 → pitch = 14'h2000 with a pitch_valid pulse. Then 0x7F 0x7F (running status) → pitch = 14'h3FFF.
- Realtime mid-message: 0x90 0x3C 0xF8 0x64 → note_on (60, 100). 0xF0 0x01 0x02 0xF7 followed by 0x3C 0x64 → no output.
- Channel filter: channel = 3, send 0x92 0x3C 0x64 → no pulse; send 0x93 0x3C 0x64 → note_on. With MIDI_OMNI_EN, both produce note_on.
- Framing and reset:
  - Byte with stop bit = 0 → frame_error pulse, no note output.
  - A 400-clk low glitch → no byte received.
  - reset asserted during the second data byte → outputs at reset values, and the next full message decodes correctly.
